// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the data-memory path: default address/data widths
// (common with the Mem model) and the arbiter/sequencer state encoding.
package cpu_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_ADDR = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR      = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Combinational two-way grant.
//   valid      in  2  request vector {valid1, valid0}
//   last_grant in  1  port that won the previous accepted request
//   grant      out 2  one-hot grant (all zero when nothing is valid)
// FIXED_PRIO != 0 makes port 0 win every tie; otherwise a tie goes to the
// port that did not win last time.
module rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = ((FIXED_PRIO != 0) || last_grant) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Arbitrates load/store requests from two requesters (port 0: CPU load/store
// stage, port 1: debug/DMA loader) and sequences them onto the single-port
// data memory, honouring its registered-read timing.
//   clk, rst                 clock, async active-high reset
//   reqN_valid/we/addr/wdata request from port N, held until reqN_ready
//   reqN_ready               accept strobe, combinational, IDLE only
//   reqN_rvalid/rdata        one-cycle load-data pulse and held load data
//   busy                     high in any non-IDLE state
//   mem_r/mem_w/mem_add      registered Mem control and address
//   mem_wdata/mem_oe         store data and drive enable for the Data bus
//   mem_rdata                Mem Data bus as seen by the arbiter
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no access in flight; arbitrate and accept one request
// ST_RD_ADDR | mem_r high, address presented; Mem registers the read
// ST_RD_DATA | mem_r and address held so Mem keeps driving Data
// ST_WR      | mem_w/mem_oe high with address and data; written at cycle end
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    output logic          req0_ready,
    output logic          req0_rvalid,
    output logic [DW-1:0] req0_rdata,

    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req1_ready,
    output logic          req1_rvalid,
    output logic [DW-1:0] req1_rdata,

    output logic          busy,
    output logic          mem_r,
    output logic          mem_w,
    output logic [AW-1:0] mem_add,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_oe,
    input  logic [DW-1:0] mem_rdata
);

    state_t        state;
    logic          last_grant;
    logic          owner;
    logic [1:0]    grant;

    logic          sel_port;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0_ready = (state == ST_IDLE) && grant[0];
    assign req1_ready = (state == ST_IDLE) && grant[1];

    assign sel_port  = grant[1];
    assign sel_we    = sel_port ? req1_we    : req0_we;
    assign sel_addr  = sel_port ? req1_addr  : req0_addr;
    assign sel_wdata = sel_port ? req1_wdata : req0_wdata;

    // The Data bus is driven exactly while a store is presented.
    assign mem_oe = mem_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            busy        <= 1'b0;
            mem_r       <= 1'b0;
            mem_w       <= 1'b0;
            mem_add     <= '0;
            mem_wdata   <= '0;
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= '0;
            req1_rdata  <= '0;
        end else begin
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        owner      <= sel_port;
                        last_grant <= sel_port;
                        mem_add    <= sel_addr;
                        busy       <= 1'b1;
                        if (sel_we) begin
                            mem_w     <= 1'b1;
                            mem_wdata <= sel_wdata;
                            state     <= ST_WR;
                        end else begin
                            mem_r <= 1'b1;
                            state <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    // Mem has been driving its registered read data for this
                    // whole cycle; take it for whichever port owns the read.
                    state <= ST_IDLE;
                    mem_r <= 1'b0;
                    busy  <= 1'b0;
                    if (owner) begin
                        req1_rdata  <= mem_rdata;
                        req1_rvalid <= 1'b1;
                    end else begin
                        req0_rdata  <= mem_rdata;
                        req0_rvalid <= 1'b1;
                    end
                end
                ST_WR: begin
                    state <= ST_IDLE;
                    mem_w <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    mem_r <= 1'b0;
                    mem_w <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Bench for dmem_arbiter: instance a (round-robin) and instance b (fixed
// priority), each attached to its own behavioural registered-read memory.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // instance a
    logic       a_req0_valid = 0, a_req0_we = 0;
    logic [7:0] a_req0_addr = 0, a_req0_wdata = 0;
    logic       a_req0_ready, a_req0_rvalid;
    logic [7:0] a_req0_rdata;
    logic       a_req1_valid = 0, a_req1_we = 0;
    logic [7:0] a_req1_addr = 0, a_req1_wdata = 0;
    logic       a_req1_ready, a_req1_rvalid;
    logic [7:0] a_req1_rdata;
    logic       a_busy, a_mem_r, a_mem_w, a_mem_oe;
    logic [7:0] a_mem_add, a_mem_wdata, a_mem_rdata;

    // instance b
    logic       b_req0_valid = 0, b_req0_we = 0;
    logic [7:0] b_req0_addr = 0, b_req0_wdata = 0;
    logic       b_req0_ready, b_req0_rvalid;
    logic [7:0] b_req0_rdata;
    logic       b_req1_valid = 0, b_req1_we = 0;
    logic [7:0] b_req1_addr = 0, b_req1_wdata = 0;
    logic       b_req1_ready, b_req1_rvalid;
    logic [7:0] b_req1_rdata;
    logic       b_busy, b_mem_r, b_mem_w, b_mem_oe;
    logic [7:0] b_mem_add, b_mem_wdata, b_mem_rdata;

    dmem_arbiter #(.AW(8), .DW(8), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(a_req0_valid), .req0_we(a_req0_we), .req0_addr(a_req0_addr),
        .req0_wdata(a_req0_wdata), .req0_ready(a_req0_ready),
        .req0_rvalid(a_req0_rvalid), .req0_rdata(a_req0_rdata),
        .req1_valid(a_req1_valid), .req1_we(a_req1_we), .req1_addr(a_req1_addr),
        .req1_wdata(a_req1_wdata), .req1_ready(a_req1_ready),
        .req1_rvalid(a_req1_rvalid), .req1_rdata(a_req1_rdata),
        .busy(a_busy), .mem_r(a_mem_r), .mem_w(a_mem_w), .mem_add(a_mem_add),
        .mem_wdata(a_mem_wdata), .mem_oe(a_mem_oe), .mem_rdata(a_mem_rdata)
    );

    dmem_arbiter #(.AW(8), .DW(8), .FIXED_PRIO(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_we(b_req0_we), .req0_addr(b_req0_addr),
        .req0_wdata(b_req0_wdata), .req0_ready(b_req0_ready),
        .req0_rvalid(b_req0_rvalid), .req0_rdata(b_req0_rdata),
        .req1_valid(b_req1_valid), .req1_we(b_req1_we), .req1_addr(b_req1_addr),
        .req1_wdata(b_req1_wdata), .req1_ready(b_req1_ready),
        .req1_rvalid(b_req1_rvalid), .req1_rdata(b_req1_rdata),
        .busy(b_busy), .mem_r(b_mem_r), .mem_w(b_mem_w), .mem_add(b_mem_add),
        .mem_wdata(b_mem_wdata), .mem_oe(b_mem_oe), .mem_rdata(b_mem_rdata)
    );

    // Memory models: registered read, write at the end of a mem_w cycle.
    // Preload contents are (re)written while reset is held.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] rdq_a = 8'h00;
    logic [7:0] rdq_b = 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            mem_a[8'h10] <= 8'hA5;
            mem_a[8'h01] <= 8'h11;
            mem_a[8'h02] <= 8'h22;
        end else begin
            if (a_mem_w) mem_a[a_mem_add] <= a_mem_wdata;
            if (a_mem_r) rdq_a <= mem_a[a_mem_add];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            mem_b[8'h01] <= 8'h11;
            mem_b[8'h02] <= 8'h22;
        end else begin
            if (b_mem_w) mem_b[b_mem_add] <= b_mem_wdata;
            if (b_mem_r) rdq_b <= mem_b[b_mem_add];
        end
    end

    assign a_mem_rdata = a_mem_oe ? a_mem_wdata : rdq_a;
    assign b_mem_rdata = b_mem_oe ? b_mem_wdata : rdq_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycle invariants on both instances.
    always @(negedge clk) begin
        if (!rst) begin
            chk("a_r_w_exclusive", 32'(a_mem_r && a_mem_w), 32'd0);
            chk("b_r_w_exclusive", 32'(b_mem_r && b_mem_w), 32'd0);
            chk("a_ready_while_busy", 32'((a_req0_ready || a_req1_ready) && a_busy), 32'd0);
            chk("b_ready_while_busy", 32'((b_req0_ready || b_req1_ready) && b_busy), 32'd0);
        end
    end

    logic [7:0] lr0 = 8'h00;
    logic [7:0] lr1 = 8'h00;

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lr0 = 8'h00;
        lr1 = 8'h00;
    endtask

    // One transaction on instance a with full cycle-by-cycle checks.
    task automatic do_op(input int p, input logic we, input logic [7:0] addr,
                         input logic [7:0] wd, input logic [7:0] exp_rd);
        int waited;
        logic rdy;
        waited = 0;
        if (p == 0) begin
            a_req0_valid = 1; a_req0_we = we; a_req0_addr = addr; a_req0_wdata = wd;
        end else begin
            a_req1_valid = 1; a_req1_we = we; a_req1_addr = addr; a_req1_wdata = wd;
        end
        #1;
        rdy = (p == 0) ? a_req0_ready : a_req1_ready;
        while (!rdy && waited < 8) begin
            @(negedge clk); #1;
            waited++;
            rdy = (p == 0) ? a_req0_ready : a_req1_ready;
        end
        chk("accept_ready", 32'(rdy), 32'd1);
        chk("accept_other_ready", 32'((p == 0) ? a_req1_ready : a_req0_ready), 32'd0);
        @(negedge clk);
        a_req0_valid = 0;
        a_req1_valid = 0;
        // T+1
        chk("t1_busy", 32'(a_busy), 32'd1);
        chk("t1_mem_add", 32'(a_mem_add), 32'(addr));
        chk("t1_rvalid_clear", 32'({a_req1_rvalid, a_req0_rvalid}), 32'd0);
        if (we) begin
            chk("wr_mem_w", 32'(a_mem_w), 32'd1);
            chk("wr_mem_oe", 32'(a_mem_oe), 32'd1);
            chk("wr_mem_r", 32'(a_mem_r), 32'd0);
            chk("wr_mem_wdata", 32'(a_mem_wdata), 32'(wd));
            @(negedge clk);
            chk("t2_mem_w_low", 32'(a_mem_w), 32'd0);
            chk("t2_mem_oe_low", 32'(a_mem_oe), 32'd0);
            chk("t2_busy_low", 32'(a_busy), 32'd0);
        end else begin
            chk("rd_t1_mem_r", 32'(a_mem_r), 32'd1);
            chk("rd_t1_mem_w", 32'(a_mem_w), 32'd0);
            @(negedge clk);
            chk("rd_t2_mem_r", 32'(a_mem_r), 32'd1);
            chk("rd_t2_mem_add", 32'(a_mem_add), 32'(addr));
            chk("rd_t2_rvalid", 32'({a_req1_rvalid, a_req0_rvalid}), 32'd0);
            @(negedge clk);
            if (p == 0) lr0 = exp_rd; else lr1 = exp_rd;
            chk("rd_t3_rvalid", 32'({a_req1_rvalid, a_req0_rvalid}), (p == 0) ? 32'd1 : 32'd2);
            chk("rd_t3_busy", 32'(a_busy), 32'd0);
            chk("rd_t3_mem_r", 32'(a_mem_r), 32'd0);
        end
        chk("rdata0_model", 32'(a_req0_rdata), 32'(lr0));
        chk("rdata1_model", 32'(a_req1_rdata), 32'(lr1));
    endtask

    typedef struct {
        int         p;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wd;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vt[8];

    initial begin
        vt[0] = '{0, 1'b0, 8'h10, 8'h00, 8'hA5};
        vt[1] = '{1, 1'b1, 8'h20, 8'h3C, 8'h00};
        vt[2] = '{1, 1'b0, 8'h20, 8'h00, 8'h3C};
        vt[3] = '{0, 1'b1, 8'hFF, 8'hFF, 8'h00};
        vt[4] = '{0, 1'b0, 8'hFF, 8'h00, 8'hFF};
        vt[5] = '{1, 1'b0, 8'h10, 8'h00, 8'hA5};
        vt[6] = '{0, 1'b1, 8'h00, 8'h5A, 8'h00};
        vt[7] = '{1, 1'b0, 8'h00, 8'h00, 8'h5A};

        // Reset state
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_a_busy", 32'(a_busy), 32'd0);
        chk("rst_a_mem", 32'({a_mem_r, a_mem_w, a_mem_oe}), 32'd0);
        chk("rst_a_mem_add", 32'(a_mem_add), 32'd0);
        chk("rst_a_mem_wdata", 32'(a_mem_wdata), 32'd0);
        chk("rst_a_rvalid", 32'({a_req1_rvalid, a_req0_rvalid}), 32'd0);
        chk("rst_a_rdata", 32'({a_req1_rdata, a_req0_rdata}), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
        chk("rst_b_mem", 32'({b_mem_r, b_mem_w, b_mem_oe, b_mem_add}), 32'd0);
        rst = 1'b0;

        // Directed vector table on the round-robin instance
        for (int i = 0; i < 8; i++) begin
            do_op(vt[i].p, vt[i].we, vt[i].addr, vt[i].wd, vt[i].exp_rd);
        end

        // Port 0 holds its request while port 1's load is in flight
        a_req1_valid = 1; a_req1_we = 0; a_req1_addr = 8'h02;
        #1 chk("hold_p1_ready", 32'(a_req1_ready), 32'd1);
        @(negedge clk);
        a_req1_valid = 0;
        a_req0_valid = 1; a_req0_we = 0; a_req0_addr = 8'h10;
        #1 chk("hold_t1_ready0", 32'(a_req0_ready), 32'd0);
        @(negedge clk);
        #1 chk("hold_t2_ready0", 32'(a_req0_ready), 32'd0);
        @(negedge clk);
        #1 chk("hold_t3_ready0", 32'(a_req0_ready), 32'd1);
        chk("hold_t3_rvalid1", 32'({a_req1_rvalid, a_req0_rvalid}), 32'd2);
        chk("hold_t3_rdata1", 32'(a_req1_rdata), 32'h22);
        @(negedge clk);
        a_req0_valid = 0;
        chk("hold_t4_busy", 32'(a_busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("hold_t6_rvalid0", 32'({a_req1_rvalid, a_req0_rvalid}), 32'd1);
        chk("hold_t6_rdata0", 32'(a_req0_rdata), 32'hA5);
        chk("hold_t6_rdata1_kept", 32'(a_req1_rdata), 32'h22);
        @(negedge clk);
        chk("hold_t7_single_accept", 32'({a_busy, a_mem_r, a_req0_rvalid}), 32'd0);

        // Reset in the middle of a read
        a_req0_valid = 1; a_req0_we = 0; a_req0_addr = 8'h10;
        #1 chk("mid_accept", 32'(a_req0_ready), 32'd1);
        @(negedge clk);
        a_req0_valid = 0;
        chk("mid_t1_mem_r", 32'(a_mem_r), 32'd1);
        @(negedge clk);
        chk("mid_t2_mem_r", 32'(a_mem_r), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_mem_r", 32'(a_mem_r), 32'd0);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lr0 = 8'h00;
        lr1 = 8'h00;
        chk("mid_no_rvalid_a", 32'({a_req1_rvalid, a_req0_rvalid}), 32'd0);
        chk("mid_rdata_cleared", 32'({a_req1_rdata, a_req0_rdata}), 32'd0);
        @(negedge clk);
        chk("mid_no_rvalid_b", 32'({a_req1_rvalid, a_req0_rvalid}), 32'd0);
        do_op(0, 1'b0, 8'h01, 8'h00, 8'h11);

        // Round-robin with both ports loading continuously from reset
        pulse_reset();
        a_req0_valid = 1; a_req0_we = 0; a_req0_addr = 8'h01;
        a_req1_valid = 1; a_req1_we = 0; a_req1_addr = 8'h02;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_ready0", 32'(a_req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", 32'(a_req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            repeat (3) @(negedge clk);
            #1;
            chk("rr_rvalid", 32'({a_req1_rvalid, a_req0_rvalid}), (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k % 2 == 0) chk("rr_rdata0", 32'(a_req0_rdata), 32'h11);
            else            chk("rr_rdata1", 32'(a_req1_rdata), 32'h22);
        end
        a_req0_valid = 0;
        a_req1_valid = 0;

        // Fixed priority: port 0 wins every tie
        b_req0_valid = 1; b_req0_we = 0; b_req0_addr = 8'h01;
        b_req1_valid = 1; b_req1_we = 0; b_req1_addr = 8'h02;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("fp_ready0", 32'(b_req0_ready), 32'd1);
            chk("fp_ready1", 32'(b_req1_ready), 32'd0);
            repeat (3) @(negedge clk);
            #1;
            chk("fp_rvalid", 32'({b_req1_rvalid, b_req0_rvalid}), 32'd1);
            chk("fp_rdata0", 32'(b_req0_rdata), 32'h11);
        end
        b_req0_valid = 0;
        #1 chk("fp_ready1_after_drop", 32'(b_req1_ready), 32'd1);
        @(negedge clk);
        b_req1_valid = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("fp_rvalid1", 32'({b_req1_rvalid, b_req0_rvalid}), 32'd2);
        chk("fp_rdata1", 32'(b_req1_rdata), 32'h22);
        chk("fp_rdata0_kept", 32'(b_req0_rdata), 32'h11);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and sequencer for the single-port 8-bit data memory (Mem). Accepts load/store requests from two requesters: port 0 is the CPU load/store stage, port 1 is the debug/DMA loader. It serialises the requests onto Mem's R/W/Add/Data pins, respecting Mem's registered-read timing. The top level builds the Mem inout from mem_wdata/mem_oe/mem_rdata.

Parameters:
AW, 8, address width (Mem depth 2**AW)
DW, 8, data width
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins on a tie

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  port 0 request; held with its fields until req0_ready
req0_we  in  1  1 = store, 0 = load
req0_addr  in  AW  port 0 address
req0_wdata  in  DW  port 0 store data
req0_ready  out  1  accept strobe (combinational, IDLE only)
req0_rvalid  out  1  one-cycle load-data-valid pulse
req0_rdata  out  DW  load data, valid while req0_rvalid
req1_*  same seven signals for port 1
busy  out  1  high in any non-IDLE state
mem_r  out  1  to Mem R
mem_w  out  1  to Mem W
mem_add  out  AW  to Mem Add
mem_wdata  out  DW  store data for the tristate driver
mem_oe  out  1  top-level drive enable for Mem Data; equals mem_w
mem_rdata  in  DW  Mem Data bus as seen by the arbiter

Behaviour:
- Reset (async, immediate): state=IDLE. mem_r=mem_w=mem_oe=0, mem_add=0, mem_wdata=0. Both rvalid=0, both rdata=0, busy=0, last_grant=1 (so port 0 is preferred first). Any in-flight read is dropped and produces no rvalid.
- States:
  - IDLE: arbitrate.
  - RD_ADDR: mem_r=1, mem_add=latched address.
  - RD_DATA: mem_r=1 and the same address held, so Mem keeps driving Data_1.
  - WR: mem_w=1, mem_oe=1, mem_add and mem_wdata latched.
- IDLE arbitration:
  - With one valid request, grant it.
  - With both valid and FIXED_PRIO=0, grant the port != last_grant. With FIXED_PRIO=1, grant port 0.
  - The granted port's ready is 1 in the same cycle. Address, data, port id and we are latched at that posedge.
  - last_grant updates only on accept.
  - Next state: we=0 goes to RD_ADDR, we=1 goes to WR.
- Transitions: RD_ADDR goes to RD_DATA, RD_DATA goes to IDLE, WR goes to IDLE. All are unconditional.
- Read capture: at the posedge ending RD_DATA, mem_rdata is registered into the owner's rdata. That port's rvalid is 1 for exactly the following cycle.
- Latency, with accept at cycle T:
  - Load: rvalid at T+3.
  - Store: written into Mem at the posedge ending T+1.
  - Next accept possible at T+3 (load) or T+2 (store).
- rdata holds its last value after rvalid falls. The non-owning port's rvalid/rdata are untouched.
- mem_r and mem_w are never both 1. All mem_* outputs are registered, which keeps them glitch-free.
- ready is never asserted outside IDLE. Requests arriving while busy wait.
- Address is used as-is, with no wrap logic; addr 255 is valid.

Decomposition:
- Shared package/header cpu_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RD_ADDR=2'd1, ST_RD_DATA=2'd2, ST_WR=2'd3
  - the AW/DW defaults, shared with Mem
- One sub-module, rr_arb2: combinational 2-way grant from {valid1,valid0}, last_grant and FIXED_PRIO. Outputs grant, one-hot[1:0].

Test Plan:
- Reset then single load: preload mem[8'h10]=8'hA5; req0 load 0x10 at T -> req0_ready@T, mem_r high T+1..T+2, req0_rvalid@T+3 with rdata=8'hA5, busy low@T+3.
- Store then load: req1 store 0x20←8'h3C -> mem_w/mem_oe high exactly one cycle (T+1); subsequent req1 load 0x20 -> rdata=8'h3C; mem_r&&mem_w never both 1.
- Simultaneous round-robin: both ports load continuously from reset (port0 addr 0x01=8'h11, port1 addr 0x02=8'h22) -> grants alternate 0,1,0,1. Each rvalid carries its own data (0x11/0x22) on its own port only.
- FIXED_PRIO=1: both valid continuously -> port 0 granted every time, port 1 never ready until req0_valid drops.
- Reset mid-read: assert rst during RD_DATA -> mem_r falls immediately, no rvalid on either port. After release the next req0 load returns correct data at accept+3.
- Boundary address: store 8'hFF to 0xFF, then load 0xFF -> rdata=8'hFF. Requester holding valid while busy sees ready only in IDLE, and its request is accepted once.
